// File: rtl/line_burst_adaptor.sv
// Cacheline <-> 4-beat burst adaptor between the cache datapath and physical memory.
// Define LBA_ERR_EN to build the sticky protocol-error flag on err_o.
module line_burst_adaptor #(
    parameter int unsigned s_line  = 256,
    parameter int unsigned s_burst = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        address_i,
    input  logic [s_line-1:0]  line_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic [s_line-1:0]  line_o,
    output logic               resp_o,
    output logic [31:0]        address_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i,
    output logic               err_o
);

    localparam int unsigned NumBeats = s_line / s_burst;
    localparam int unsigned CntW     = $clog2(NumBeats);
    localparam logic [CntW-1:0] LastBeat = CntW'(NumBeats - 1);

    typedef enum logic [1:0] {StIdle, StRdBurst, StWrBurst, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [s_line-1:0]  line_q, line_d;
    logic [s_line-1:0]  wr_line_q, wr_line_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            line_q    <= '0;
            wr_line_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            wr_line_q <= wr_line_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        line_d    = line_q;
        wr_line_d = wr_line_q;
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        burst_o   = '0;
        unique case (state_q)
            StIdle: begin
                // Write-back goes first so the victim leaves before the fill lands.
                if (write_i) begin
                    addr_d    = address_i;
                    wr_line_d = line_i;
                    cnt_d     = '0;
                    state_d   = StWrBurst;
                end else if (read_i) begin
                    addr_d  = address_i;
                    cnt_d   = '0;
                    state_d = StRdBurst;
                end
            end
            StRdBurst: begin
                read_o = 1'b1;
                if (resp_i) begin
                    line_d[s_burst*cnt_q +: s_burst] = burst_i;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastBeat) state_d = StDone;
                end
            end
            StWrBurst: begin
                write_o = 1'b1;
                burst_o = wr_line_q[s_burst*cnt_q +: s_burst];
                if (resp_i) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastBeat) state_d = StDone;
                end
            end
            StDone: begin
                resp_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign line_o    = line_q;
    assign address_o = addr_q & ~32'h1F;

`ifdef LBA_ERR_EN
    logic err_q;
    logic err_set;

    // Either a conflicting request pair or a stalled beat after the burst has started.
    assign err_set = ((state_q == StIdle) && read_i && write_i) ||
                     (((state_q == StRdBurst) || (state_q == StWrBurst)) &&
                      !resp_i && (cnt_q != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
